// File: rtl/lc3_trace_buffer.sv
// lc3_trace_buffer: two-stage instruction-fetch trace capture into a first-word-fall-through FIFO.
module lc3_trace_buffer #(
    parameter int          DEPTH   = 16,
    parameter int          TS_W    = 16,
    parameter logic [15:0] HALT_IR = 16'hF025
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ld_ir_obs,
    input  logic [15:0]              pc_value,
    input  logic [15:0]              ir_value,
    input  logic                     trc_en,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_pc,
    output logic [15:0]              out_ir,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic                     halted
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]     pc_mem [DEPTH];
    logic [15:0]     ir_mem [DEPTH];
    logic [TS_W-1:0] ts_mem [DEPTH];
    logic [TS_W-1:0] ts;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            cap_pend, pop, full, wr_en, drop;

    assign out_valid = count != '0;
    assign pop       = out_valid & out_ready;
    assign full      = count == (AW+1)'(DEPTH);
    // A pop frees the slot the pending capture needs, so full-with-pop still writes.
    assign wr_en     = cap_pend & (~full | pop);
    assign drop      = cap_pend & full & ~pop;
    assign out_pc    = pc_mem[rd_ptr];
    assign out_ir    = ir_mem[rd_ptr];
    assign out_ts    = ts_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cap_pend <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            halted   <= 1'b0;
        end else if (clear) begin
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            cap_pend <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            halted   <= 1'b0;
        end else begin
            ts       <= ts + TS_W'(1);
            cap_pend <= ld_ir_obs & trc_en & ~halted;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= drop_cnt + 8'(drop_cnt != 8'hFF);
            end
            if (cap_pend && ir_value == HALT_IR) halted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr] <= pc_value;
            ir_mem[wr_ptr] <= ir_value;
            ts_mem[wr_ptr] <= ts;
        end
    end
endmodule

// File: tb/tb_lc3_trace_buffer.sv
// tb_lc3_trace_buffer: directed and randomized checks against a queue-based trace model.
module tb_lc3_trace_buffer;
    localparam int DEPTH = 16;

    logic        clk = 0, reset = 1, ld_ir_obs = 0, trc_en = 0, clear = 0, out_ready = 0;
    logic [15:0] pc_value = 0, ir_value = 0;
    logic        out_valid, overflow, halted;
    logic [15:0] out_pc, out_ir, out_ts;
    logic [4:0]  count;
    logic [7:0]  drop_cnt;
    int          passed = 0, total = 0;

    lc3_trace_buffer dut (
        .clk(clk), .reset(reset), .ld_ir_obs(ld_ir_obs), .pc_value(pc_value),
        .ir_value(ir_value), .trc_en(trc_en), .clear(clear), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir), .out_ts(out_ts),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] pc, ir, ts;} ent_t;
    ent_t        mq[$];
    bit          m_pend = 0, m_ovf = 0, m_halt = 0, m_pop, m_was_halt;
    int          m_drop = 0;
    logic [15:0] m_ts = 0;

    // Reference: a strobe seen at one edge is recorded at the next; the oldest entry leaves first.
    always @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            mq.delete();
            m_pend = 0; m_ovf = 0; m_halt = 0; m_drop = 0; m_ts = 0;
        end else begin
            m_was_halt = m_halt;
            m_pop = mq.size() > 0 && out_ready;
            if (m_pop) void'(mq.pop_front());
            if (m_pend) begin
                if (mq.size() < DEPTH) mq.push_back('{pc_value, ir_value, m_ts});
                else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
                if (ir_value == 16'hF025) m_halt = 1;
            end
            m_pend = ld_ir_obs && trc_en && !m_was_halt;
            m_ts++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [15:0] ir, input logic [15:0] pc);
        ld_ir_obs = 1;
        @(negedge clk);
        ld_ir_obs = 0; ir_value = ir; pc_value = pc;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        clear = 1;
        @(negedge clk);
        clear = 0;
    endtask

    task automatic test_reset();
        tick(2);
        total++; if (out_valid !== 0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (count !== 0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
        total++; if ({overflow, halted, drop_cnt} !== 10'd0) $display("FAIL reset_flags: got %b/%b/%0d want 0/0/0", overflow, halted, drop_cnt); else passed++;
        reset = 0;
        tick(1);
    endtask

    task automatic test_single();
        trc_en = 1; out_ready = 0;
        ld_ir_obs = 1;
        @(negedge clk);
        ld_ir_obs = 0; ir_value = 16'h1221; pc_value = 16'h3001;
        total++; if (out_valid !== 0) $display("FAIL single_early: got %b want 0", out_valid); else passed++;
        @(negedge clk);
        total++; if (out_valid !== 1) $display("FAIL single_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_pc !== 16'h3001) $display("FAIL single_pc: got %h want 3001", out_pc); else passed++;
        total++; if (out_ir !== 16'h1221) $display("FAIL single_ir: got %h want 1221", out_ir); else passed++;
        total++; if (mq.size() != 1 || out_ts !== mq[0].ts) $display("FAIL single_ts: got %h want %h", out_ts, mq.size() ? mq[0].ts : 16'hx); else passed++;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        total++; if (count !== 0) $display("FAIL single_drain: got %0d want 0", count); else passed++;
    endtask

    task automatic test_overflow();
        pulse_clear();
        out_ready = 0;
        for (int i = 0; i < 17; i++) strobe(16'(i), 16'(16'h3000 + i));
        total++; if (count !== 16) $display("FAIL ovf_count: got %0d want 16", count); else passed++;
        total++; if (overflow !== 1) $display("FAIL ovf_flag: got %b want 1", overflow); else passed++;
        total++; if (drop_cnt !== 1) $display("FAIL ovf_drop: got %0d want 1", drop_cnt); else passed++;
        total++; if (out_ir !== 0) $display("FAIL ovf_head: got %h want 0000", out_ir); else passed++;
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            total++; if (out_ir !== 16'(i) || out_pc !== 16'(16'h3000 + i)) $display("FAIL ovf_order%0d: got %h/%h want %h/%h", i, out_ir, out_pc, 16'(i), 16'(16'h3000 + i)); else passed++;
            @(negedge clk);
        end
        out_ready = 0;
        total++; if (count !== 0 || overflow !== 1) $display("FAIL ovf_after: got %0d/%b want 0/1", count, overflow); else passed++;
    endtask

    task automatic test_full_push_pop();
        pulse_clear();
        for (int i = 0; i < 16; i++) strobe(16'(16'h0100 + i), 16'(16'h4000 + i));
        ld_ir_obs = 1;
        @(negedge clk);
        ld_ir_obs = 0; ir_value = 16'h2000; pc_value = 16'h4ABC; out_ready = 1;
        total++; if (count !== 16 || out_ir !== 16'h0100) $display("FAIL full_pre: got %0d/%h want 16/0100", count, out_ir); else passed++;
        @(negedge clk);
        out_ready = 0;
        total++; if (count !== 16) $display("FAIL full_count: got %0d want 16", count); else passed++;
        total++; if (overflow !== 0 || drop_cnt !== 0) $display("FAIL full_nodrop: got %b/%0d want 0/0", overflow, drop_cnt); else passed++;
        total++; if (out_ir !== 16'h0101) $display("FAIL full_head: got %h want 0101", out_ir); else passed++;
        out_ready = 1;
        for (int i = 0; i < 16; i++) begin
            total++; if (out_ir !== (i < 15 ? 16'(16'h0101 + i) : 16'h2000)) $display("FAIL full_order%0d: got %h want %h", i, out_ir, (i < 15 ? 16'(16'h0101 + i) : 16'h2000)); else passed++;
            @(negedge clk);
        end
        out_ready = 0;
    endtask

    task automatic test_back_to_back();
        pulse_clear();
        ld_ir_obs = 1;
        @(negedge clk);
        ir_value = 16'hAAAA; pc_value = 16'h3010;
        @(negedge clk);
        ld_ir_obs = 0; ir_value = 16'hBBBB; pc_value = 16'h3011;
        @(negedge clk);
        total++; if (count !== 2 || out_ir !== 16'hAAAA) $display("FAIL b2b_first: got %0d/%h want 2/aaaa", count, out_ir); else passed++;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        total++; if (count !== 1 || out_ir !== 16'hBBBB || out_pc !== 16'h3011) $display("FAIL b2b_second: got %0d/%h/%h want 1/bbbb/3011", count, out_ir, out_pc); else passed++;
    endtask

    task automatic test_halt();
        pulse_clear();
        strobe(16'h1111, 16'h3000);
        strobe(16'hF025, 16'h3001);
        total++; if (halted !== 1 || count !== 2) $display("FAIL halt_set: got %b/%0d want 1/2", halted, count); else passed++;
        for (int i = 0; i < 3; i++) strobe(16'(16'h2220 + i), 16'(16'h3002 + i));
        total++; if (count !== 2 || halted !== 1) $display("FAIL halt_frozen: got %0d/%b want 2/1", count, halted); else passed++;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        total++; if (count !== 1 || out_ir !== 16'hF025) $display("FAIL halt_drain: got %0d/%h want 1/f025", count, out_ir); else passed++;
        pulse_clear();
        total++; if ({count, halted, overflow, drop_cnt} !== 15'd0) $display("FAIL halt_clear: got %0d/%b/%b/%0d want 0/0/0/0", count, halted, overflow, drop_cnt); else passed++;
        strobe(16'h3333, 16'h3100);
        total++; if (count !== 1 || out_ir !== 16'h3333) $display("FAIL halt_resume: got %0d/%h want 1/3333", count, out_ir); else passed++;
    endtask

    task automatic test_async_reset();
        pulse_clear();
        for (int i = 0; i < 5; i++) strobe(16'(16'h0500 + i), 16'h3000);
        ld_ir_obs = 1;
        @(posedge clk);
        #2 reset = 1;
        #1;
        total++; if (out_valid !== 0) $display("FAIL areset_valid: got %b want 0", out_valid); else passed++;
        total++; if (count !== 0) $display("FAIL areset_count: got %0d want 0", count); else passed++;
        @(negedge clk);
        reset = 0; ld_ir_obs = 0;
        tick(2);
        total++; if (count !== 0) $display("FAIL areset_pending: got %0d want 0", count); else passed++;
        strobe(16'h5555, 16'h3200);
        total++; if (count !== 1 || out_ir !== 16'h5555 || out_pc !== 16'h3200) $display("FAIL areset_post: got %0d/%h/%h want 1/5555/3200", count, out_ir, out_pc); else passed++;
        total++; if (mq.size() != 1 || out_ts !== mq[0].ts) $display("FAIL areset_ts: got %h want %h", out_ts, mq.size() ? mq[0].ts : 16'hx); else passed++;
    endtask

    task automatic test_stall_ts();
        logic [15:0] t0;
        pulse_clear();
        out_ready = 0;
        strobe(16'h7001, 16'h3300);
        tick(2);
        strobe(16'h7002, 16'h3301);
        t0 = mq[0].ts;
        for (int i = 0; i < 10; i++) begin
            total++; if (out_valid !== 1 || out_ir !== 16'h7001 || out_pc !== 16'h3300 || out_ts !== t0) $display("FAIL stall%0d: got %b/%h/%h/%h want 1/7001/3300/%h", i, out_valid, out_ir, out_pc, out_ts, t0); else passed++;
            @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        total++; if (out_ir !== 16'h7002 || out_ts !== 16'(t0 + 4)) $display("FAIL ts_delta: got %h/%h want 7002/%h", out_ir, out_ts, 16'(t0 + 4)); else passed++;
    endtask

    task automatic test_random();
        pulse_clear();
        for (int c = 0; c < 600; c++) begin
            ld_ir_obs = 1'($urandom_range(0, 1));
            trc_en    = $urandom_range(0, 3) != 0;
            out_ready = (c < 250) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            clear     = $urandom_range(0, 149) == 0;
            ir_value  = ($urandom_range(0, 99) == 0) ? 16'hF025 : 16'($urandom);
            pc_value  = 16'($urandom);
            @(negedge clk);
            total++; if (out_valid !== (mq.size() != 0) || count !== 5'(mq.size())) $display("FAIL rnd_count@%0d: got %b/%0d want %0d", c, out_valid, count, mq.size()); else passed++;
            total++; if (overflow !== m_ovf || drop_cnt !== 8'(m_drop) || halted !== m_halt) $display("FAIL rnd_flags@%0d: got %b/%0d/%b want %b/%0d/%b", c, overflow, drop_cnt, halted, m_ovf, m_drop, m_halt); else passed++;
            if (mq.size() != 0) begin
                total++; if (out_pc !== mq[0].pc || out_ir !== mq[0].ir || out_ts !== mq[0].ts) $display("FAIL rnd_head@%0d: got %h/%h/%h want %h/%h/%h", c, out_pc, out_ir, out_ts, mq[0].pc, mq[0].ir, mq[0].ts); else passed++;
            end
        end
        clear = 0; ld_ir_obs = 0; out_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_halt();
        test_async_reset();
        test_stall_ts();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
